regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter DATA_W, default 13, sets the width of the datapath and the register value.
REQ-002 Parameter ADDR_W, default 3, sets the register-address width (r0-r7).
REQ-003 Port clk, input, 1 bit: the single clock. All state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port i_valid, input, 1 bit: an instruction is offered on i_instr.
REQ-006 Port i_instr, input, DATA_W bits: instruction fields are opcode [12:9], rd [8:6], rs [5:3], rt [2:0].
REQ-007 Port o_ready, output, 1 bit: the sequencer accepts an instruction this cycle.
REQ-008 Port o_done, output, 1 bit: one-cycle pulse marking instruction completion.
REQ-009 Port o_err, output, 1 bit: one-cycle pulse marking an illegal opcode or an rd=7 write.
REQ-010 Ports o_memRead and o_memWrite, output, 1 bit each: read and write enables toward the register file.
REQ-011 Ports o_address1, o_address2 and o_destReg, output, ADDR_W bits each: the rs, rt and rd addresses.
REQ-012 Port o_ALUresult, output, DATA_W bits: the writeback data.
REQ-013 Ports i_dataA and i_dataB, input, DATA_W bits each: the register-file read data.
REQ-014 Port o_retired, output, 16 bits: present only under REQ-031.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, EXEC and WRITE, with transitions IDLE->READ on i_valid&&o_ready, then READ->EXEC->WRITE->IDLE unconditionally.
REQ-016 o_ready SHALL be 1 only in IDLE; i_instr SHALL be latched on the accept edge.
REQ-017 READ: o_memRead=1, o_address1=rs, o_address2=rt; all other enables 0.
REQ-018 EXEC: the operands SHALL be taken from i_dataA and i_dataB, which the register file has registered at the end of READ; the result SHALL be registered at the end of EXEC.
REQ-019 Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: each computes A op B.
- 5 NOT A.
- 6 A<<1, 7 A>>1 (logical).
- 8 MOV A.
- 9 NOP, with no writeback.
- 10-15 are illegal.
REQ-020 All arithmetic SHALL be modulo 2^DATA_W; carry and borrow SHALL be discarded.
REQ-021 WRITE: o_memWrite=1 with o_destReg=rd and o_ALUresult=result, unless the opcode is NOP, illegal, or rd=7.
REQ-022 Illegal opcode or rd=7: o_memWrite SHALL stay 0 and o_err SHALL pulse in the WRITE cycle.
REQ-023 o_done SHALL pulse in the WRITE cycle for every accepted instruction, including errored ones.
REQ-024 Latency: for an accept at edge N, WRITE occupies cycle N+3 and o_ready is 1 again in cycle N+4. Throughput SHALL be one instruction per 4 cycles.
REQ-025 i_valid in a non-IDLE state SHALL be ignored and no instruction SHALL be queued.
REQ-026 o_memRead and o_memWrite SHALL never both be 1.

Reset
REQ-027 While reset=1 the state SHALL be IDLE and every output SHALL be 0 except o_ready, which SHALL also be 0.
REQ-028 Reset asserted mid-instruction SHALL abandon it: no o_memWrite, no o_done and no o_err.
REQ-029 In the first cycle after reset deasserts, o_ready SHALL be 1.
REQ-030 The latched instruction and operand registers SHALL clear to 0 on reset.

Configuration
REQ-031 With macro REGFILE_SEQUENCER_PERF_EN defined, o_retired SHALL count o_done pulses that had no o_err. It SHALL wrap from 0xFFFF to 0 and clear on reset.
REQ-032 Without REGFILE_SEQUENCER_PERF_EN, the o_retired port and its counter SHALL not exist.

Structure
REQ-033 The opcode constants, the FSM state encoding, and the instruction field positions SHALL live in the shared package proc_pkg.
REQ-034 The opcode datapath SHALL be a combinational sub-module seq_alu (inputs op, A, B; output result and illegal flag). The FSM and registers SHALL stay in regfile_sequencer.

Verification
REQ-035 The bench SHALL model a register file with 1-cycle read latency that zeros its outputs when idle, and SHALL cover these scenarios:
- r1=5, r2=3, ADD r3,r1,r2 -> WRITE cycle shows o_memWrite=1, o_destReg=3, o_ALUresult=8, and o_done=1.
- SUB r4,r2,r1 with r2=3, r1=5 -> o_ALUresult=0x1FFE.
- SHL1 on A=0x1000 -> o_ALUresult=0x0000.
- Opcode 0xF, then ADD with rd=7 -> each gives o_err=1, o_done=1, o_memWrite=0, with no register change.
- i_valid held high with 3 instructions -> accepts at cycles 0, 4 and 8, and o_ready=0 in between.
- Reset asserted during EXEC -> no o_memWrite and no o_done, and o_ready=1 in the cycle after reset deasserts.
- With PERF_EN: 2 good instructions and 1 illegal -> o_retired=2.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states
// and instruction field positions.
`timescale 1ns/1ps
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_NOP = 4'd9;

  localparam int OP_MSB = 12;
  localparam int OP_LSB = 9;
  localparam int RD_MSB = 8;
  localparam int RD_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 3;
  localparam int RT_MSB = 2;
  localparam int RT_LSB = 0;

  // r7 is read-only; writes to it are flagged as errors.
  localparam logic [2:0] RD_RESERVED = 3'd7;

endpackage

// File: rtl/seq_alu.sv
// Combinational opcode datapath for the sequencer; all arithmetic wraps
// modulo 2^DATA_W, and opcodes 10-15 raise illegal_o.
`timescale 1ns/1ps
module seq_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 13
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_SHL:  result_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR:  result_o = {1'b0, a_i[DATA_W-1:1]};
      OP_MOV:  result_o = a_i;
      OP_NOP:  result_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-state IDLE/READ/EXEC/WRITE instruction sequencer in front of a register
// file. Optional retired-instruction counter under REGFILE_SEQUENCER_PERF_EN.
`timescale 1ns/1ps
module regfile_sequencer
  import proc_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_instr,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic              o_memRead,
  output logic              o_memWrite,
  output logic [ADDR_W-1:0] o_address1,
  output logic [ADDR_W-1:0] o_address2,
  output logic [ADDR_W-1:0] o_destReg,
  output logic [DATA_W-1:0] o_ALUresult,
  input  logic [DATA_W-1:0] i_dataA,
  input  logic [DATA_W-1:0] i_dataB
`ifdef REGFILE_SEQUENCER_PERF_EN
  , output logic [15:0]     o_retired
`endif
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   instr_q;
  logic [DATA_W-1:0]   result_q;
  logic                err_q;
  logic                wen_q;

  logic [3:0]          op_w;
  logic [2:0]          rd_w;
  logic [2:0]          rs_w;
  logic [2:0]          rt_w;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_illegal;
  logic                accept;

  assign op_w   = instr_q[OP_MSB:OP_LSB];
  assign rd_w   = instr_q[RD_MSB:RD_LSB];
  assign rs_w   = instr_q[RS_MSB:RS_LSB];
  assign rt_w   = instr_q[RT_MSB:RT_LSB];
  assign accept = i_valid && o_ready;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (op_w),
    .a_i       (i_dataA),
    .b_i       (i_dataB),
    .result_o  (alu_result),
    .illegal_o (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= i_instr;
      end
      // Writeback decision is frozen together with the result at end of EXEC.
      if (state_q == ST_EXEC) begin
        result_q <= alu_result;
        err_q    <= alu_illegal || ((rd_w == RD_RESERVED) && (op_w != OP_NOP));
        wen_q    <= !alu_illegal && (op_w != OP_NOP) && (rd_w != RD_RESERVED);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_memRead   = 1'b0;
    o_memWrite  = 1'b0;
    o_address1  = '0;
    o_address2  = '0;
    o_destReg   = '0;
    o_ALUresult = '0;
    // Outputs are forced low while reset is held, even mid-instruction.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          o_ready = 1'b1;
          if (i_valid) begin
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          o_memRead  = 1'b1;
          o_address1 = rs_w;
          o_address2 = rt_w;
          state_d    = ST_EXEC;
        end
        ST_EXEC: begin
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          o_done  = 1'b1;
          o_err   = err_q;
          state_d = ST_IDLE;
          if (wen_q) begin
            o_memWrite  = 1'b1;
            o_destReg   = rd_w;
            o_ALUresult = result_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef REGFILE_SEQUENCER_PERF_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if ((state_q == ST_WRITE) && !err_q) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized self-checking bench for regfile_sequencer with a 1-cycle-latency
// register file model and an instruction-level reference model.
`timescale 1ns/1ps
module tb_regfile_sequencer;

  localparam int DW = 13;
  localparam int AW = 3;
  localparam int MASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [DW-1:0] i_instr;
  logic          o_ready, o_done, o_err, o_memRead, o_memWrite;
  logic [AW-1:0] o_address1, o_address2, o_destReg;
  logic [DW-1:0] o_ALUresult;
  logic [DW-1:0] i_dataA, i_dataB;
`ifdef REGFILE_SEQUENCER_PERF_EN
  logic [15:0]   o_retired;
`endif

  int errors = 0;
  int checks = 0;

  // register file model (owned by the bench) and reference-model shadow copy
  logic [DW-1:0] rf [8];
  int            shadow [8];
  int            good_done = 0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_instr     (i_instr),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_memRead   (o_memRead),
    .o_memWrite  (o_memWrite),
    .o_address1  (o_address1),
    .o_address2  (o_address2),
    .o_destReg   (o_destReg),
    .o_ALUresult (o_ALUresult),
    .i_dataA     (i_dataA),
    .i_dataB     (i_dataB)
`ifdef REGFILE_SEQUENCER_PERF_EN
    , .o_retired (o_retired)
`endif
  );

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (o_memWrite) rf[o_destReg] <= o_ALUresult;
    if (o_memRead) begin
      i_dataA <= rf[o_address1];
      i_dataB <= rf[o_address2];
    end else begin
      i_dataA <= '0;
      i_dataB <= '0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int op, input int rd, input int rs, input int rt);
    return DW'((op << 9) | (rd << 6) | (rs << 3) | rt);
  endfunction

  task automatic set_reg(input int r, input int v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = AW'(r); pre_data = DW'(v);
    @(negedge clk);
    pre_we = 1'b0;
    shadow[r] = v & MASK;
  endtask

  // Instruction-level reference: reads shadow[rs]/[rt], writes shadow[rd].
  task automatic model_exec(input logic [DW-1:0] ins, output int res, output bit wr, output bit er);
    int op, rd, a, b;
    op = int'(ins[12:9]); rd = int'(ins[8:6]);
    a = shadow[int'(ins[5:3])]; b = shadow[int'(ins[2:0])];
    res = 0; wr = 1'b1; er = 1'b0;
    case (op)
      0: res = (a + b) & MASK;
      1: res = (a - b) & MASK;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = MASK - a;
      6: res = (a * 2) & MASK;
      7: res = a / 2;
      8: res = a;
      9: wr = 1'b0;
      default: begin wr = 1'b0; er = 1'b1; end
    endcase
    if (wr && rd == 7) begin wr = 1'b0; er = 1'b1; end
    if (wr) shadow[rd] = res;
    if (!er) good_done++;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!o_ready && t < 20) begin @(negedge clk); t++; end
    if (!o_ready) check_eq("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  // Issue one instruction from IDLE and check READ and WRITE cycles.
  task automatic run_instr(input logic [DW-1:0] ins, output logic [DW-1:0] got_res,
                           output logic got_err, output logic got_we);
    int res; bit wr, er;
    wait_ready();
    model_exec(ins, res, wr, er);
    i_valid = 1'b1; i_instr = ins;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check_eq("read_en", 32'(o_memRead), 32'd1);
    check_eq("read_addr1", 32'(o_address1), 32'(ins[5:3]));
    check_eq("read_addr2", 32'(o_address2), 32'(ins[2:0]));
    check_eq("read_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    check_eq("exec_done", 32'(o_done), 32'd0);
    @(negedge clk);
    check_eq("wr_done", 32'(o_done), 32'd1);
    check_eq("wr_err", 32'(o_err), 32'(er));
    check_eq("wr_en", 32'(o_memWrite), 32'(wr));
    check_eq("wr_no_read", 32'(o_memRead), 32'd0);
    if (wr) begin
      check_eq("wr_dest", 32'(o_destReg), 32'(ins[8:6]));
      check_eq("wr_data", 32'(o_ALUresult), 32'(res));
    end
    got_res = o_ALUresult; got_err = o_err; got_we = o_memWrite;
    @(negedge clk);
    check_eq("idle_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic e, w;
    logic [DW-1:0] prog [3];
    int k;

    reset = 1'b1; i_valid = 1'b0; i_instr = '0;
    for (int i = 0; i < 8; i++) begin rf[i] = '0; shadow[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(o_ready), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    check_eq("rst_rw", 32'({o_memRead, o_memWrite}), 32'd0);
    check_eq("rst_addr", 32'({o_address1, o_address2, o_destReg}), 32'd0);
    check_eq("rst_result", 32'(o_ALUresult), 32'd0);
`ifdef REGFILE_SEQUENCER_PERF_EN
    check_eq("rst_retired", 32'(o_retired), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(o_ready), 32'd1);

    // directed scenarios
    set_reg(1, 5); set_reg(2, 3);
    run_instr(mk(0, 3, 1, 2), r, e, w);
    check_eq("add_8", 32'(r), 32'd8);
    run_instr(mk(1, 4, 2, 1), r, e, w);
    check_eq("sub_wrap", 32'(r), 32'h1FFE);
    set_reg(5, 'h1000);
    run_instr(mk(6, 6, 5, 0), r, e, w);
    check_eq("shl_top", 32'(r), 32'd0);
    check_eq("shl_we", 32'(w), 32'd1);
    run_instr(mk(15, 2, 1, 1), r, e, w);
    check_eq("illegal_err", 32'({e, w}), 32'b10);
    run_instr(mk(0, 7, 1, 2), r, e, w);
    check_eq("rd7_err", 32'({e, w}), 32'b10);

    // i_valid held high across three instructions
    prog[0] = mk(8, 1, 3, 0); prog[1] = mk(4, 2, 1, 4); prog[2] = mk(3, 3, 2, 6);
    wait_ready();
    k = 0;
    i_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int res; bit wr, er;
      if (k < 3) i_instr = prog[k];
      check_eq("held_ready", 32'(o_ready), 32'((c % 4) == 0));
      if (o_ready && k < 3) begin
        check_eq("held_accept_cycle", 32'(c), 32'(k * 4));
        model_exec(prog[k], res, wr, er);
        k++;
      end
      if (c == 11) i_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("held_accepts", 32'(k), 32'd3);

    // reset during EXEC abandons the instruction
    wait_ready();
    i_valid = 1'b1; i_instr = mk(0, 5, 1, 2);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_eq("rstx_we", 32'(o_memWrite), 32'd0);
      check_eq("rstx_done", 32'(o_done), 32'd0);
      check_eq("rstx_err", 32'(o_err), 32'd0);
      check_eq("rstx_ready", 32'(o_ready), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    good_done = 0;
    @(negedge clk);
    check_eq("rstx_ready_after", 32'(o_ready), 32'd1);

    // two good instructions and one illegal
    run_instr(mk(0, 1, 1, 2), r, e, w);
    run_instr(mk(2, 2, 1, 2), r, e, w);
    run_instr(mk(12, 3, 0, 0), r, e, w);
`ifdef REGFILE_SEQUENCER_PERF_EN
    check_eq("perf_retired2", 32'(o_retired), 32'd2);
`endif

    // randomized instruction stream
    for (int i = 0; i < 7; i++) set_reg(i, int'($urandom_range(0, MASK)));
    for (int n = 0; n < 40; n++) begin
      int op, rd;
      op = int'($urandom_range(0, 15));
      rd = int'($urandom_range(0, 7));
      if (op == 9 && rd == 7) rd = 0;
      run_instr(mk(op, rd, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))), r, e, w);
    end

    for (int i = 0; i < 8; i++) check_eq("final_reg", 32'(rf[i]), 32'(shadow[i]));
`ifdef REGFILE_SEQUENCER_PERF_EN
    check_eq("perf_retired_final", 32'(o_retired), 32'(good_done & 'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
